// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite draw path: ROM word layout, screen limits, sequencer states.
package sprite_pkg;

    localparam int DX_HI      = 15;
    localparam int DX_LO      = 11;
    localparam int DY_HI      = 10;
    localparam int DY_LO      = 6;
    localparam int RSVD_HI    = 5;
    localparam int RSVD_LO    = 4;
    localparam int COL_HI     = 3;
    localparam int COL_LO     = 1;
    localparam int OPAQUE_BIT = 0;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_word_decode.sv
// Registered decode/clip of one sprite ROM word into a plot request; 1 cycle latency.
// No backpressure: x/y/colour load on every valid slot, the write strobe only for opaque on-screen pixels.
module sprite_word_decode
    import sprite_pkg::*;
#(
    parameter int         X_MAX     = SCREEN_X_MAX,
    parameter int         Y_MAX     = SCREEN_Y_MAX,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vld,
    input  logic [15:0] word,
    input  logic [7:0]  ox,
    input  logic [6:0]  oy,
    input  logic        erase,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        we
);

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       we_q, we_d;
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       on_screen;
    logic       rsvd_unused;

    assign rsvd_unused = ^word[RSVD_HI:RSVD_LO];

    always_comb begin
        // Sums are one bit wider than the screen coordinate so overflow clips instead of wrapping.
        x_sum     = {1'b0, ox} + {4'b0, word[DX_HI:DX_LO]};
        y_sum     = {1'b0, oy} + {3'b0, word[DY_HI:DY_LO]};
        on_screen = (x_sum <= 9'(X_MAX)) && (y_sum <= 8'(Y_MAX));
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        if (vld) begin
            x_d      = x_sum[7:0];
            y_d      = y_sum[6:0];
            colour_d = erase ? BG_COLOUR : word[COL_HI:COL_LO];
        end
        we_d = vld && word[OPAQUE_BIT] && on_screen;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign we     = we_q;

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Sweeps the sprite ROM once per start and streams decoded plot requests; first writeEn 2 cycles after start.
// No backpressure: start is honoured only in IDLE, all other starts are dropped.
module sprite_draw_sequencer
    import sprite_pkg::*;
#(
    parameter int         DEPTH     = 840,
    parameter int         ADDR_W    = 10,
    parameter int         X_MAX     = SCREEN_X_MAX,
    parameter int         Y_MAX     = SCREEN_Y_MAX,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              erase,
    input  logic [7:0]        x_coord,
    input  logic [6:0]        y_coord,
    output logic [ADDR_W-1:0] addr_read,
    input  logic [15:0]       rom_word,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              writeEn,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vld0_q, vld0_d;
    logic              vld1_q, vld1_d;
    logic              drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        ox_q, ox_d;
    logic [6:0]        oy_q, oy_d;
    logic              erase_q, erase_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        vld0_d  = 1'b0;
        vld1_d  = vld0_q;
        drain_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ox_d    = ox_q;
        oy_d    = oy_q;
        erase_d = erase_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ox_d    = x_coord;
                    oy_d    = y_coord;
                    erase_d = erase;
                    addr_d  = '0;
                    vld0_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    vld0_d = 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles: one for the ROM read, one for the decode register.
                if (drain_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            erase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            erase_q <= erase_d;
        end
    end

    sprite_word_decode #(
        .X_MAX     (X_MAX),
        .Y_MAX     (Y_MAX),
        .BG_COLOUR (BG_COLOUR)
    ) u_decode (
        .clock  (clock),
        .reset  (reset),
        .vld    (vld1_q),
        .word   (rom_word),
        .ox     (ox_q),
        .oy     (oy_q),
        .erase  (erase_q),
        .x      (x),
        .y      (y),
        .colour (colour),
        .we     (writeEn)
    );

    assign addr_read = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Bench for sprite_draw_sequencer: table vectors on chosen ROM entries plus randomized full passes vs a plain-arithmetic model.
module tb_sprite_draw_sequencer;

    localparam int DEPTH = 840;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        erase = 1'b0;
    logic [7:0]  x_coord = '0;
    logic [6:0]  y_coord = '0;
    logic [9:0]  addr_read;
    logic [15:0] rom_word = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:1023];

    int total = 0;
    int bad   = 0;

    int cap_we, cap_x, cap_y, cap_col;

    typedef struct {
        int idx;
        int ox;
        int oy;
        bit er;
        int dx;
        int dy;
        int col;
        bit op;
        int exp_we;
        int exp_x;
        int exp_y;
        int exp_col;
    } vec_t;

    vec_t vecs [12];

    sprite_draw_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .erase     (erase),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .addr_read (addr_read),
        .rom_word  (rom_word),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Synchronous sprite ROM: data for an address appears one edge later.
    always @(posedge clock) rom_word <= rom[addr_read];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: screen position is origin plus offset; anything beyond the screen edge is not drawn.
    function automatic void model(input logic [15:0] w, input int ox, input int oy, input bit er,
                                  output int we, output int ex, output int ey, output int ec);
        int wi, dx, dy, op, sx, sy;
        wi = int'(w);
        dx = (wi / 2048) % 32;
        dy = (wi / 64) % 32;
        op = wi % 2;
        sx = ox + dx;
        sy = oy + dy;
        we = (op == 1 && sx <= 159 && sy <= 119) ? 1 : 0;
        ex = sx % 256;
        ey = sy % 128;
        ec = er ? 0 : (wi / 2) % 8;
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    endtask

    task automatic run_pass(input int ox, input int oy, input bit er, input int restart_at,
                            input int reset_at, input bit start_on_done, input int cap_idx);
        int we, ex, ey, ec, k, exp_wr, act_wr, done_seen, wr_seen;
        exp_wr = 0;
        act_wr = 0;
        @(negedge clock);
        start   = 1'b1;
        x_coord = 8'(ox);
        y_coord = 7'(oy);
        erase   = er;
        for (int c = 0; c <= 845; c++) begin
            @(negedge clock);
            if (c == 0) begin
                start   = 1'b0;
                x_coord = 8'($urandom);
                y_coord = 7'($urandom);
                erase   = 1'($urandom);
            end
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("abort busy c=%0d", c), int'(busy), 0);
                check($sformatf("abort writeEn c=%0d", c), int'(writeEn), 0);
                check($sformatf("abort addr c=%0d", c), int'(addr_read), 0);
                check($sformatf("abort x c=%0d", c), int'(x), 0);
                @(negedge clock);
                reset = 1'b0;
                done_seen = 0;
                wr_seen = 0;
                for (int j = 0; j < 850; j++) begin
                    @(negedge clock);
                    done_seen += int'(done);
                    wr_seen   += int'(writeEn) + int'(busy);
                end
                check("no done after abort", done_seen, 0);
                check("idle after abort", wr_seen, 0);
                return;
            end
            if (c == restart_at) begin
                start   = 1'b1;
                x_coord = 8'($urandom);
                y_coord = 7'($urandom);
                erase   = ~er;
            end
            if (c == restart_at + 1) start = 1'b0;

            if (c <= 842)
                check($sformatf("addr c=%0d", c), int'(addr_read), (c < DEPTH - 1) ? c : DEPTH - 1);
            check($sformatf("busy c=%0d", c), int'(busy), (c <= 841) ? 1 : 0);
            check($sformatf("done c=%0d", c), int'(done), (c == 842) ? 1 : 0);

            k = c - 2;
            if (k >= 0 && k < DEPTH) begin
                model(rom[k], ox, oy, er, we, ex, ey, ec);
                exp_wr += we;
                check($sformatf("writeEn slot %0d", k), int'(writeEn), we);
                check($sformatf("x slot %0d", k), int'(x), ex);
                check($sformatf("y slot %0d", k), int'(y), ey);
                check($sformatf("colour slot %0d", k), int'(colour), ec);
                if (k == cap_idx) begin
                    cap_we  = int'(writeEn);
                    cap_x   = int'(x);
                    cap_y   = int'(y);
                    cap_col = int'(colour);
                end
            end else begin
                check($sformatf("no write c=%0d", c), int'(writeEn), 0);
            end
            act_wr += int'(writeEn);

            if (start_on_done && c == 842) start = 1'b1;
            if (start_on_done && c == 843) start = 1'b0;
        end
        check("write count", act_wr, exp_wr);
    endtask

    initial begin
        vecs[0]  = '{0,   10,  20,  1'b0, 3,  4,  5, 1'b1, 1, 13,  24,  5};
        vecs[1]  = '{0,   10,  20,  1'b0, 3,  4,  5, 1'b0, 0, 13,  24,  5};
        vecs[2]  = '{5,   150, 110, 1'b0, 15, 5,  2, 1'b1, 0, 165, 115, 2};
        vecs[3]  = '{6,   150, 110, 1'b0, 9,  9,  7, 1'b1, 1, 159, 119, 7};
        vecs[4]  = '{0,   30,  40,  1'b1, 1,  1,  6, 1'b1, 1, 31,  41,  0};
        vecs[5]  = '{1,   30,  40,  1'b1, 1,  1,  6, 1'b0, 0, 31,  41,  0};
        vecs[6]  = '{839, 0,   0,   1'b0, 0,  0,  1, 1'b1, 1, 0,   0,   1};
        vecs[7]  = '{839, 159, 119, 1'b0, 0,  0,  3, 1'b1, 1, 159, 119, 3};
        vecs[8]  = '{10,  159, 0,   1'b0, 1,  0,  4, 1'b1, 0, 160, 0,   4};
        vecs[9]  = '{10,  0,   119, 1'b0, 0,  1,  4, 1'b1, 0, 0,   120, 4};
        vecs[10] = '{2,   255, 127, 1'b0, 31, 31, 7, 1'b1, 0, 30,  30,  7};
        vecs[11] = '{3,   128, 100, 1'b0, 31, 19, 2, 1'b1, 1, 159, 119, 2};

        fill_rom();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset addr", int'(addr_read), 0);
        check("reset x", int'(x), 0);
        check("reset y", int'(y), 0);
        check("reset colour", int'(colour), 0);
        check("reset writeEn", int'(writeEn), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        reset = 1'b0;

        for (int v = 0; v < 12; v++) begin
            fill_rom();
            rom[vecs[v].idx] = 16'((vecs[v].dx << 11) | (vecs[v].dy << 6) | ($urandom_range(0, 3) << 4)
                                   | (vecs[v].col << 1) | int'(vecs[v].op));
            run_pass(vecs[v].ox, vecs[v].oy, vecs[v].er, -10, -10, 1'b0, vecs[v].idx);
            check($sformatf("vec%0d writeEn", v), cap_we, vecs[v].exp_we);
            check($sformatf("vec%0d x", v), cap_x, vecs[v].exp_x);
            check($sformatf("vec%0d y", v), cap_y, vecs[v].exp_y);
            check($sformatf("vec%0d colour", v), cap_col, vecs[v].exp_col);
        end

        fill_rom();
        run_pass(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), 1'b0, 100, -10, 1'b0, -1);
        fill_rom();
        run_pass(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), 1'b1, -10, -10, 1'b1, -1);
        fill_rom();
        run_pass(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), 1'b0, -10, 300, 1'b0, -1);
        for (int p = 0; p < 3; p++) begin
            fill_rom();
            run_pass(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1'($urandom), -10, -10, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
